// File: rtl/crono_countdown_if.sv
// Bundle between the chronometer-configuration editor, the countdown engine
// and the display/alarm logic. The countdown engine is the slave side.
interface crono_countdown_if;
    logic [7:0] Hcr_in;
    logic [7:0] Mcr_in;
    logic [7:0] Scr_in;
    logic       EN;
    logic       BTstart;
    logic       BTclr;
    logic [7:0] Hcd;
    logic [7:0] Mcd;
    logic [7:0] Scd;
    logic       running;
    logic       alarm;

    modport master (
        output Hcr_in, Mcr_in, Scr_in, EN, BTstart, BTclr,
        input  Hcd, Mcd, Scd, running, alarm
    );

    modport slave (
        input  Hcr_in, Mcr_in, Scr_in, EN, BTstart, BTclr,
        output Hcd, Mcd, Scd, running, alarm
    );
endinterface

// File: rtl/crono_countdown.sv
// 1 Hz HH:MM:SS countdown with start/pause/clear buttons and expiry alarm.
// Optional macro CCOUNT_ALARM_TIMEOUT_EN: alarm clears itself after ALARM_SECS ticks.
module crono_countdown #(
    parameter int TICK_DIV   = 100000000,
    parameter int HMAX       = 23,
    parameter int ALARM_SECS = 10
) (
    input logic               clk,
    input logic               reset,
    crono_countdown_if.slave  bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    if (TICK_DIV < 2 || ALARM_SECS < 1) begin : g_bad_cfg
        $error("crono_countdown: TICK_DIV must be >= 2 and ALARM_SECS >= 1");
    end

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

    state_e          state_q, state_d;
    logic [7:0]      h_q, h_d, m_q, m_d, s_q, s_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            start_ref_q, clr_ref_q;
    logic            running_q, running_d;
    logic            alarm_q, alarm_d;

    logic            start_edge, clr_edge, tick;
    logic [7:0]      h_ld, m_ld, s_ld;
    logic            load_zero;
    logic [7:0]      h_dec, m_dec, s_dec;
    logic            dec_zero;

`ifdef CCOUNT_ALARM_TIMEOUT_EN
    logic [7:0]      dcnt_q, dcnt_d;
`endif

    assign start_edge = bus.BTstart & ~start_ref_q;
    assign clr_edge   = bus.BTclr & ~clr_ref_q;
    assign tick       = (presc_q == PW'(TICK_DIV - 1));

    assign h_ld      = (bus.Hcr_in > 8'(HMAX)) ? 8'(HMAX) : bus.Hcr_in;
    assign m_ld      = (bus.Mcr_in > 8'd59) ? 8'd59 : bus.Mcr_in;
    assign s_ld      = (bus.Scr_in > 8'd59) ? 8'd59 : bus.Scr_in;
    assign load_zero = (h_ld == '0) && (m_ld == '0) && (s_ld == '0);

    // One-second decrement with minute/hour borrow.
    always_comb begin
        h_dec = h_q;
        m_dec = m_q;
        s_dec = s_q;
        if (s_q != '0) begin
            s_dec = s_q - 8'd1;
        end else if (m_q != '0) begin
            s_dec = 8'd59;
            m_dec = m_q - 8'd1;
        end else if (h_q != '0) begin
            s_dec = 8'd59;
            m_dec = 8'd59;
            h_dec = h_q - 8'd1;
        end
        dec_zero = (h_dec == '0) && (m_dec == '0) && (s_dec == '0);
    end

    // State register and all output/datapath flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            h_q         <= '0;
            m_q         <= '0;
            s_q         <= '0;
            presc_q     <= '0;
            start_ref_q <= 1'b0;
            clr_ref_q   <= 1'b0;
            running_q   <= 1'b0;
            alarm_q     <= 1'b0;
`ifdef CCOUNT_ALARM_TIMEOUT_EN
            dcnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            m_q         <= m_d;
            s_q         <= s_d;
            presc_q     <= presc_d;
            start_ref_q <= bus.BTstart;
            clr_ref_q   <= bus.BTclr;
            running_q   <= running_d;
            alarm_q     <= alarm_d;
`ifdef CCOUNT_ALARM_TIMEOUT_EN
            dcnt_q      <= dcnt_d;
`endif
        end
    end

    // Next-state logic; clear outranks start, and expiry outranks a same-cycle pause.
    always_comb begin
        state_d = state_q;
        if (!bus.EN) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_edge && !clr_edge && !load_zero) state_d = RUN;
                end
                RUN: begin
                    if (clr_edge)              state_d = IDLE;
                    else if (tick && dec_zero) state_d = DONE;
                    else if (start_edge)       state_d = PAUSE;
                end
                PAUSE: begin
                    if (clr_edge)        state_d = IDLE;
                    else if (start_edge) state_d = RUN;
                end
                DONE: begin
                    if (start_edge || clr_edge) state_d = IDLE;
`ifdef CCOUNT_ALARM_TIMEOUT_EN
                    else if (tick && dcnt_q == 8'(ALARM_SECS - 1)) state_d = IDLE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath and registered-output next values.
    always_comb begin
        h_d       = h_q;
        m_d       = m_q;
        s_d       = s_q;
        presc_d   = presc_q;
        running_d = (state_d == RUN);
        alarm_d   = (state_d == DONE);
`ifdef CCOUNT_ALARM_TIMEOUT_EN
        dcnt_d    = (state_q == DONE) ? dcnt_q : '0;
`endif
        if (!bus.EN) begin
            h_d     = h_ld;
            m_d     = m_ld;
            s_d     = s_ld;
            presc_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    h_d     = h_ld;
                    m_d     = m_ld;
                    s_d     = s_ld;
                    presc_d = '0;
                end
                RUN: begin
                    if (clr_edge) begin
                        presc_d = '0;
                    end else if (tick) begin
                        h_d     = h_dec;
                        m_d     = m_dec;
                        s_d     = s_dec;
                        presc_d = '0;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                PAUSE: begin
                    if (clr_edge) presc_d = '0;
                end
                DONE: begin
                    h_d     = '0;
                    m_d     = '0;
                    s_d     = '0;
                    presc_d = '0;
`ifdef CCOUNT_ALARM_TIMEOUT_EN
                    if (state_d == DONE) begin
                        presc_d = tick ? '0 : presc_q + PW'(1);
                        if (tick) dcnt_d = dcnt_q + 8'd1;
                    end
`endif
                end
                default: presc_d = '0;
            endcase
        end
    end

    assign bus.Hcd     = h_q;
    assign bus.Mcd     = m_q;
    assign bus.Scd     = s_q;
    assign bus.running = running_q;
    assign bus.alarm   = alarm_q;

endmodule

// File: tb/tb_crono_countdown.sv
// Bench for crono_countdown: vector table, directed corner sequences and a
// random run, all checked against a total-seconds reference model.
module tb_crono_countdown;

    localparam int TD = 4;
    localparam int HM = 23;
    localparam int AS = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    crono_countdown_if bus();

    crono_countdown #(.TICK_DIV(TD), .HMAX(HM), .ALARM_SECS(AS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef enum int {MI, MR, MP, MD} mmode_e;
    mmode_e md_mode;
    int     md_rem, md_phase, md_dcnt;
    logic   md_rs, md_rc;

    typedef struct {
        int en, bs, bc, h, m, s;
        int eh, em, es, er, ea;
    } vec_t;

    function automatic int clamp_total(input int h, input int m, input int s);
        if (h > HM) h = HM;
        if (m > 59) m = 59;
        if (s > 59) s = 59;
        return h * 3600 + m * 60 + s;
    endfunction

    function automatic logic [31:0] exp_vec();
        return {6'b0, 8'(md_rem / 3600), 8'((md_rem / 60) % 60), 8'(md_rem % 60),
                md_mode == MR, md_mode == MD};
    endfunction

    function automatic logic [31:0] act_vec();
        return {6'b0, bus.Hcd, bus.Mcd, bus.Scd, bus.running, bus.alarm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        md_mode = MI; md_rem = 0; md_phase = 0; md_dcnt = 0;
        md_rs = 1'b0; md_rc = 1'b0;
    endtask

    task automatic model_clock();
        logic se, ce, tk;
        int ld;
        se = bus.BTstart & ~md_rs;
        ce = bus.BTclr & ~md_rc;
        md_rs = bus.BTstart;
        md_rc = bus.BTclr;
        ld = clamp_total(int'(bus.Hcr_in), int'(bus.Mcr_in), int'(bus.Scr_in));
        tk = (md_phase == TD - 1);
        if (!bus.EN) begin
            md_mode = MI; md_rem = ld; md_phase = 0;
        end else begin
            case (md_mode)
                MI: begin
                    md_rem = ld; md_phase = 0;
                    if (se && !ce && ld != 0) md_mode = MR;
                end
                MR: begin
                    if (ce) begin
                        md_mode = MI; md_phase = 0;
                    end else if (tk) begin
                        md_rem--; md_phase = 0;
                        if (md_rem == 0) begin md_mode = MD; md_dcnt = 0; end
                        else if (se) md_mode = MP;
                    end else begin
                        md_phase++;
                        if (se) md_mode = MP;
                    end
                end
                MP: begin
                    if (ce) begin md_mode = MI; md_phase = 0; end
                    else if (se) md_mode = MR;
                end
                MD: begin
                    if (se || ce) begin md_mode = MI; md_phase = 0; end
`ifdef CCOUNT_ALARM_TIMEOUT_EN
                    else if (tk) begin
                        md_phase = 0; md_dcnt++;
                        if (md_dcnt == AS) md_mode = MI;
                    end else md_phase++;
`endif
                end
                default: md_mode = MI;
            endcase
        end
    endtask

    task automatic drive(input int en, input int bs, input int bc, input int h, input int m, input int s);
        bus.EN = 1'(en); bus.BTstart = 1'(bs); bus.BTclr = 1'(bc);
        bus.Hcr_in = 8'(h); bus.Mcr_in = 8'(m); bus.Scr_in = 8'(s);
    endtask

    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
        check("model", act_vec(), exp_vec());
    endtask

    task automatic set_btn(input int bs, input int bc);
        bus.BTstart = 1'(bs); bus.BTclr = 1'(bc);
    endtask

    vec_t tbl[15];
    int n;

    initial begin
        // Hours/minutes/seconds expected, then running, alarm.
        tbl[0]  = '{1, 0, 0,  1,  2,  3,   1,  2,  3, 0, 0};
        tbl[1]  = '{1, 0, 0, 70, 75, 99,  23, 59, 59, 0, 0};
        tbl[2]  = '{1, 0, 0,  0,  0,  0,   0,  0,  0, 0, 0};
        tbl[3]  = '{1, 1, 0,  0,  0,  0,   0,  0,  0, 0, 0};
        tbl[4]  = '{1, 0, 0,  0,  0,  0,   0,  0,  0, 0, 0};
        tbl[5]  = '{0, 1, 0,  2,  0,  0,   2,  0,  0, 0, 0};
        tbl[6]  = '{1, 1, 0,  2,  0,  0,   2,  0,  0, 0, 0};
        tbl[7]  = '{1, 0, 0,  2,  0,  0,   2,  0,  0, 0, 0};
        tbl[8]  = '{1, 1, 0,  2,  0,  0,   2,  0,  0, 1, 0};
        tbl[9]  = '{1, 0, 0,  2,  0,  0,   2,  0,  0, 1, 0};
        tbl[10] = '{1, 0, 0,  2,  0,  0,   2,  0,  0, 1, 0};
        tbl[11] = '{1, 0, 0,  2,  0,  0,   2,  0,  0, 1, 0};
        tbl[12] = '{1, 0, 0,  2,  0,  0,   1, 59, 59, 1, 0};
        tbl[13] = '{1, 1, 1,  2,  0,  0,   1, 59, 59, 0, 0};
        tbl[14] = '{1, 0, 0,  2,  0,  0,   2,  0,  0, 0, 0};

        drive(0, 0, 0, 1, 2, 3);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", act_vec(), 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].en, tbl[i].bs, tbl[i].bc, tbl[i].h, tbl[i].m, tbl[i].s);
            step();
            check($sformatf("row%0d", i), act_vec(),
                  {6'b0, 8'(tbl[i].eh), 8'(tbl[i].em), 8'(tbl[i].es), 1'(tbl[i].er), 1'(tbl[i].ea)});
        end

        // One minute run down to expiry, then clear and reload.
        drive(1, 0, 0, 0, 1, 0);
        step();
        set_btn(1, 0); step(); set_btn(0, 0);
        check("t2_running", 32'(bus.running), 32'd1);
        repeat (4) step();
        check("t2_first_tick", {16'b0, bus.Mcd, bus.Scd}, {16'b0, 8'd0, 8'd59});
        n = 0;
        while (!bus.alarm && n < 300) begin step(); n++; end
        check("t2_expiry_clks", 32'(n), 32'd236);
        check("t2_done", act_vec(), 32'h1);
        set_btn(0, 1); step(); set_btn(0, 0);
        check("t2_clear", act_vec(), 32'h0);
        step();
        check("t2_reload", act_vec(), {6'b0, 8'd0, 8'd1, 8'd0, 2'b00});

        // Pause after two ticks, hold, resume.
        drive(1, 0, 0, 0, 0, 5);
        step();
        set_btn(1, 0); step(); set_btn(0, 0);
        repeat (8) step();
        check("t4_two_ticks", 32'(bus.Scd), 32'd3);
        set_btn(1, 0); step(); set_btn(0, 0);
        repeat (20) step();
        check("t4_paused", act_vec(), {6'b0, 8'd0, 8'd0, 8'd3, 2'b00});
        set_btn(1, 0); step(); set_btn(0, 0);
        n = 0;
        while (!bus.alarm && n < 40) begin step(); n++; end
        check("t4_resume_clks", 32'(n), 32'd11);
        set_btn(0, 1); step(); set_btn(0, 0); step();

        // Tick coinciding with clear: no decrement.
        set_btn(1, 0); step(); set_btn(0, 0);
        repeat (3) step();
        set_btn(0, 1); step(); set_btn(0, 0);
        check("tick_with_clr", act_vec(), {6'b0, 8'd0, 8'd0, 8'd5, 2'b00});
        step();

        // Tick coinciding with start: decrement, then pause.
        set_btn(1, 0); step(); set_btn(0, 0);
        repeat (3) step();
        set_btn(1, 0); step(); set_btn(0, 0);
        check("tick_with_pause", act_vec(), {6'b0, 8'd0, 8'd0, 8'd4, 2'b00});
        repeat (6) step();
        set_btn(0, 1); step(); set_btn(0, 0); step();

        // Alarm duration.
        drive(1, 0, 0, 0, 0, 1);
        step();
        set_btn(1, 0); step(); set_btn(0, 0);
        n = 0;
        while (!bus.alarm && n < 20) begin step(); n++; end
        check("t6_expired", 32'(bus.alarm), 32'd1);
        n = 1;
        while (bus.alarm && n < 100) begin step(); if (bus.alarm) n++; end
`ifdef CCOUNT_ALARM_TIMEOUT_EN
        check("t6_alarm_clks", 32'(n), 32'(AS * TD));
`else
        check("t6_alarm_clks", 32'(n), 32'd100);
`endif
        set_btn(0, 1); step(); set_btn(0, 0); step();

        // Asynchronous reset in the middle of a run.
        drive(1, 0, 0, 0, 0, 7);
        step();
        set_btn(1, 0); step(); set_btn(0, 0);
        repeat (5) step();
        reset = 1'b0;
        #2;
        check("async_reset", act_vec(), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.EN      = ($urandom_range(0, 99) != 0);
            bus.BTstart = ($urandom_range(0, 11) == 0);
            bus.BTclr   = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) == 0) begin
                bus.Hcr_in = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'd0;
                bus.Mcr_in = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 1));
                bus.Scr_in = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
